// File: rtl/alu_cmd_issuer.sv
// Command-side issuer for the top_cpu ALU datapath: buffers valid/ready
// commands in a small FIFO, drives each one onto the CPU stimulus ports for
// a fixed settle latency, samples out_wb and returns it over a valid/ready
// response port. Divide-by-zero commands are answered without issuing.
module alu_cmd_issuer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RESULT_LAT = 2,
   parameter logic [3:0]  ALU_OPCODE = 4'b0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_f0,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic        cmd_cin,
   input  logic        cmd_bin,
   output logic [1:0]  alu_f0,
   output logic [3:0]  alu_opcode,
   output logic [15:0] alu_inp1,
   output logic [15:0] alu_inp2,
   output logic        alu_cin,
   output logic        alu_bin,
   input  logic [15:0] alu_out_wb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [1:0]  rsp_f0,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
   localparam logic [LW-1:0] LAT_INIT = LW'(RESULT_LAT - 1);

   typedef struct packed {
      logic [1:0]  f0;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        bin;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state, next_state;
   cmd_t            mem [FIFO_DEPTH];
   logic [PW-1:0]   rptr, wptr;
   logic [CW-1:0]   count;
   cmd_t            head, op_q;
   logic [LW-1:0]   lat_cnt;
   logic            push, pop, head_div0;

   assign cmd_ready = (count != CW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign head      = mem[rptr];
   assign head_div0 = (head.f0 == 2'b11) && (head.b == '0);
   assign busy      = (count != '0) || (state != IDLE);

   // FIFO storage: payload only, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {cmd_f0, cmd_a, cmd_b, cmd_cin, cmd_bin};
   end

   // FIFO pointers and occupancy; pointers wrap modulo the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and port drive; ALU ports read zero outside the issue window
   always_comb begin
      next_state = state;
      alu_opcode = '0;
      alu_f0     = '0;
      alu_inp1   = '0;
      alu_inp2   = '0;
      alu_cin    = 1'b0;
      alu_bin    = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) next_state = head_div0 ? RESP : ISSUE;
         end
         ISSUE: begin
            alu_opcode = ALU_OPCODE;
            alu_f0     = op_q.f0;
            alu_inp1   = op_q.a;
            alu_inp2   = op_q.b;
            alu_cin    = op_q.cin;
            alu_bin    = op_q.bin;
            if (lat_cnt == '0) next_state = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand load, settle counter and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         lat_cnt  <= '0;
         rsp_data <= '0;
         rsp_f0   <= '0;
         rsp_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  op_q    <= head;
                  lat_cnt <= LAT_INIT;
                  if (head_div0) begin
                     rsp_data <= '1;
                     rsp_f0   <= head.f0;
                     rsp_err  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (lat_cnt == '0) begin
                  rsp_data <= alu_out_wb;
                  rsp_f0   <= op_q.f0;
                  rsp_err  <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural CPU datapath model.
module tb_alu_cmd_issuer;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned RESULT_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_f0;
   logic [15:0] cmd_a, cmd_b;
   logic        cmd_cin, cmd_bin;
   logic [1:0]  alu_f0;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_inp1, alu_inp2;
   logic        alu_cin, alu_bin;
   logic [15:0] alu_out_wb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_f0;
   logic        rsp_err;
   logic        busy;

   alu_cmd_issuer #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .RESULT_LAT(RESULT_LAT),
      .ALU_OPCODE(4'b0001)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_f0(cmd_f0), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_cin(cmd_cin), .cmd_bin(cmd_bin),
      .alu_f0(alu_f0), .alu_opcode(alu_opcode),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2),
      .alu_cin(alu_cin), .alu_bin(alu_bin),
      .alu_out_wb(alu_out_wb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_f0(rsp_f0), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // CPU datapath stand-in: responds only while the arithmetic unit is selected
   always_comb begin
      alu_out_wb = 16'h0000;
      if (alu_opcode == 4'b0001) begin
         case (alu_f0)
            2'b00:   alu_out_wb = alu_inp1 + alu_inp2 + {15'b0, alu_cin};
            2'b01:   alu_out_wb = alu_inp1 - alu_inp2 - {15'b0, alu_bin};
            2'b10:   alu_out_wb = alu_inp1 * alu_inp2;
            default: alu_out_wb = (alu_inp2 != 16'h0) ? alu_inp1 / alu_inp2 : 16'h0;
         endcase
      end
   end

   typedef struct {
      logic [15:0] data;
      logic [1:0]  f0;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   fails   = 0;

   // Expected response from the command alone
   function automatic exp_t model(input logic [1:0] f0, input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic bi);
      exp_t e;
      int unsigned ua, ub, r;
      ua = 32'(a);
      ub = 32'(b);
      e.f0  = f0;
      e.err = 1'b0;
      case (f0)
         2'b00:   r = ua + ub + 32'(ci);
         2'b01:   r = ua - ub - 32'(bi);
         2'b10:   r = ua * ub;
         default: r = (ub == 0) ? 32'hFFFF : ua / ub;
      endcase
      if (f0 == 2'b11 && ub == 0) e.err = 1'b1;
      e.data = r[15:0];
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [1:0] f0, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic bi);
      bit acc;
      acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_f0 = f0; cmd_a = a; cmd_b = b; cmd_cin = ci; cmd_bin = bi;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
      end
      if (acc) sb.push_back(model(f0, a, b, ci, bi));
      else begin
         vectors++;
         fails++;
         $display("FAIL send_timeout: got cmd_ready=0 expected accept within 300 cycles");
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && !busy;
      end
      if (!done) begin
         vectors++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: pops the scoreboard on every response handshake and checks
   // issue-window length, spacing between windows, and response hold.
   int          run = 0;
   int          gap = 100;
   int          windows_done = 0;
   int          nonerr_popped = 0;
   bit          hold_pending = 1'b0;
   logic [15:0] hold_data;
   logic [1:0]  hold_f0;
   logic        hold_err;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         run = 0; gap = 100; windows_done = 0; nonerr_popped = 0; hold_pending = 1'b0;
      end else begin
         if (alu_opcode == 4'b0001) begin
            if (run == 0) check("gap_between_issues_ge2", 32'(gap >= 2), 32'd1);
            run++;
         end else begin
            check("opcode_idle_zero", 32'(alu_opcode), 32'd0);
            if (run != 0) begin
               check("issue_window_len", 32'(run), 32'(RESULT_LAT));
               windows_done++;
               gap = 0;
            end
            run = 0;
            gap++;
         end
         if (rsp_valid) begin
            if (hold_pending) begin
               check("hold_data", 32'(rsp_data), 32'(hold_data));
               check("hold_f0",   32'(rsp_f0),   32'(hold_f0));
               check("hold_err",  32'(rsp_err),  32'(hold_err));
            end
            hold_pending = !rsp_ready;
            hold_data = rsp_data; hold_f0 = rsp_f0; hold_err = rsp_err;
         end else begin
            hold_pending = 1'b0;
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               fails++;
               $display("FAIL unexpected_rsp: got data %0h expected no response", rsp_data);
            end else begin
               e = sb.pop_front();
               check("rsp_data", 32'(rsp_data), 32'(e.data));
               check("rsp_f0",   32'(rsp_f0),   32'(e.f0));
               check("rsp_err",  32'(rsp_err),  32'(e.err));
               if (e.err) check("no_issue_for_err", 32'(windows_done), 32'(nonerr_popped));
               else begin
                  check("issue_per_rsp", 32'(windows_done), 32'(nonerr_popped + 1));
                  nonerr_popped++;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ops;
      bit stop;
      cmd_valid = 1'b0; cmd_f0 = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_bin = 1'b0;
      rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_opcode",    32'(alu_opcode), 32'd0);
      check("rst_inp1",      32'(alu_inp1),  32'd0);
      rst_n = 1'b1;
      #1 check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b1;

      // single add: latency and issue-window length
      send(2'b00, 16'd120, 16'd10, 1'b0, 1'b0);
      lat = -1; ops = 0;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         @(negedge clk);
         if (alu_opcode == 4'b0001) ops++;
         if (rsp_valid) begin
            lat = k - 1;
            check("first_rsp_data", 32'(rsp_data), 32'd130);
         end
      end
      check("latency_edges", 32'(lat), 32'(RESULT_LAT + 1));
      check("issue_cycles",  32'(ops), 32'(RESULT_LAT));
      drain();

      // back-to-back sub, mul, div
      send(2'b01, 16'd120, 16'd10, 1'b0, 1'b0);
      send(2'b10, 16'd120, 16'd10, 1'b0, 1'b0);
      send(2'b11, 16'd120, 16'd10, 1'b0, 1'b0);
      drain();

      // divide by zero followed by an add
      send(2'b11, 16'd120, 16'd0, 1'b0, 1'b0);
      send(2'b00, 16'd5, 16'd7, 1'b1, 1'b0);
      drain();

      // back-pressure: fill the FIFO behind a stalled response
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(2'b00, 16'(100 + i), 16'd3, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_busy",      32'(busy),      32'd1);
      fork
         send(2'b01, 16'd500, 16'd1, 1'b0, 1'b1);
         begin
            repeat (3) @(posedge clk);
            #1 check("bp_still_full", 32'(cmd_ready), 32'd0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
         end
      join
      rsp_ready = 1'b1;
      drain();

      // reset while an operation is being issued with three queued
      for (int i = 0; i < 5; i++) send(2'b00, 16'(i), 16'd2, 1'b0, 1'b0);
      stop = 1'b0;
      for (int k = 0; k < 50 && !stop; k++) begin
         @(negedge clk);
         stop = (alu_opcode == 4'b0001);
      end
      check("reached_issue", 32'(stop), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_opcode",    32'(alu_opcode), 32'd0);
      check("arst_inp1",      32'(alu_inp1),   32'd0);
      check("arst_inp2",      32'(alu_inp2),   32'd0);
      check("arst_rsp_valid", 32'(rsp_valid),  32'd0);
      check("arst_rsp_data",  32'(rsp_data),   32'd0);
      check("arst_busy",      32'(busy),       32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(rsp_valid), 32'd0);
         check("post_rst_busy",  32'(busy),      32'd0);
         check("post_rst_ready", 32'(cmd_ready), 32'd1);
      end
      @(posedge clk); #1;

      // pointer wrap-around
      for (int i = 0; i < 10; i++) send(2'b00, 16'(i), 16'd1, 1'b0, 1'b0);
      drain();

      // randomized traffic with random back-pressure
      stop = 1'b0;
      fork
         begin
            for (int n = 0; n < 80; n++) begin
               logic [1:0]  f;
               logic [15:0] b;
               f = 2'($urandom_range(0, 3));
               b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
               send(f, 16'($urandom), b, 1'($urandom), 1'($urandom));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge clk);
               #1 rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
